// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter for two byte requesters feeding one 8N1 UART transmitter
module uart_tx_sched #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  output logic       o_req1_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_grant
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;
  localparam logic [11:0] LP_CNT_LAST = 12'(CLKS_PER_BIT - 1);
  logic [1:0]  r_state;
  logic [11:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_last;
  logic        r_grant;
  logic        r_tx;
  logic        r_busy;
  logic        w_idle;
  logic        w_win0;
  logic        w_win1;
  logic        w_rdy0;
  logic        w_rdy1;
  logic        w_accept;
  logic        w_bit_end;
  logic [7:0]  w_sel_data;
  // Arbitration: a lone requester wins; on a tie the one not granted last wins
  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    w_win0     = i_req0_valid & (~i_req1_valid | r_last);
    w_win1     = i_req1_valid & (~i_req0_valid | ~r_last);
    w_rdy0     = w_idle & i_rst_n & w_win0;
    w_rdy1     = w_idle & i_rst_n & w_win1;
    w_accept   = w_rdy0 | w_rdy1;
    w_sel_data = w_rdy1 ? i_req1_data : i_req0_data;
    w_bit_end  = (r_cnt == LP_CNT_LAST);
  end
  // Frame sequencer: START, eight LSB-first DATA bits, STOP, each CLKS_PER_BIT cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift <= w_sel_data;
            r_grant <= w_rdy1;
            r_last  <= w_rdy1;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        default: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
      endcase
    end
  end
  assign o_req0_ready = w_rdy0;
  assign o_req1_ready = w_rdy1;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_grant      = r_grant;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of arbitration, framing and reset behaviour with CLKS_PER_BIT=4
module tb_uart_tx_sched;
  logic       i_clk;
  logic       i_rst_n;
  logic       i_req0_valid;
  logic [7:0] i_req0_data;
  logic       o_req0_ready;
  logic       i_req1_valid;
  logic [7:0] i_req1_data;
  logic       o_req1_ready;
  logic       o_tx;
  logic       o_busy;
  logic       o_grant;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  uart_tx_sched #(.CLKS_PER_BIT(4)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_req0_valid(i_req0_valid),
    .i_req0_data(i_req0_data),
    .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid),
    .i_req1_data(i_req1_data),
    .o_req1_ready(o_req1_ready),
    .o_tx(o_tx),
    .o_busy(o_busy),
    .o_grant(o_grant)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  // Called just after a negedge; returns at the negedge following the acceptance edge
  task automatic wait_accept(output int w);
    w = -1;
    for (int i = 0; i < 200 && w < 0; i++) begin
      #1;
      if (i_req0_valid && o_req0_ready) w = 0;
      else if (i_req1_valid && o_req1_ready) w = 1;
      @(negedge i_clk);
    end
  endtask
  // Called at the negedge of the first START cycle; ends at the idle negedge after STOP
  task automatic check_frame(input string tag, input logic [7:0] d, input logic g, input bit pulse1);
    logic [7:0] rx;
    logic exp_tx;
    rx = '0;
    for (int k = 0; k < 40; k++) begin
      if (pulse1) i_req1_valid = (k >= 5 && k < 8);
      #1;
      exp_tx = (k < 4) ? 1'b0 : (k >= 36) ? 1'b1 : d[(k / 4 - 1) & 7];
      if (k % 4 == 2 && k >= 4 && k < 36) rx[k / 4 - 1] = o_tx;
      chk(tag, 32'({o_tx, o_busy, o_req0_ready, o_req1_ready}), 32'({exp_tx, 3'b100}));
      @(negedge i_clk);
    end
    #1;
    chk({tag, "_grant"}, 32'(o_grant), 32'(g));
    chk({tag, "_byte"}, 32'(rx), 32'(d));
    chk({tag, "_end"}, 32'({o_tx, o_busy}), 32'(2'b10));
  endtask
  initial begin
    int w;
    int t_prev;
    int t;
    bit quiet;
    i_rst_n = 1'b0;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    i_req0_data = 8'h00;
    i_req1_data = 8'h00;
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_outs", 32'({o_tx, o_busy, o_grant}), 32'(3'b100));
    chk("rst_ready", 32'({o_req0_ready, o_req1_ready}), 32'(2'b00));
    i_rst_n = 1'b1;
    i_req1_valid = 1'b0;
    i_req0_data = 8'h55;
    #1;
    chk("post_rst_ready", 32'({o_req0_ready, o_req1_ready}), 32'(2'b10));
    wait_accept(w);
    chk("single_who", 32'(w), 32'(0));
    i_req0_valid = 1'b0;
    check_frame("single", 8'h55, 1'b0, 1'b0);
    chk("single_idle_ready", 32'({o_req0_ready, o_req1_ready}), 32'(2'b00));
    i_rst_n = 1'b0;
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    i_req0_data = 8'hA5;
    i_req1_data = 8'h3C;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_accept(w);
      t = cyc;
      chk("tie_who", 32'(w), 32'(i % 2));
      if (i > 0) chk("tie_gap", 32'(t - t_prev), 32'd41);
      t_prev = t;
      check_frame("tie", (i % 2 == 1) ? 8'h3C : 8'hA5, 1'(i % 2), 1'b0);
    end
    i_req0_valid = 1'b0;
    i_req1_data = 8'h81;
    for (int i = 0; i < 3; i++) begin
      wait_accept(w);
      t = cyc;
      chk("solo_who", 32'(w), 32'd1);
      chk("solo_gap", 32'(t - t_prev), 32'd41);
      t_prev = t;
      check_frame("solo", 8'h81, 1'b1, 1'b0);
    end
    i_req1_data = 8'hFF;
    wait_accept(w);
    chk("mid_who", 32'(w), 32'd1);
    i_req1_valid = 1'b0;
    repeat (17) @(negedge i_clk);
    #1;
    chk("mid_bit3", 32'({o_tx, o_busy, o_grant}), 32'(3'b111));
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    i_req0_data = 8'h5A;
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst", 32'({o_tx, o_busy, o_grant, o_req0_ready, o_req1_ready}), 32'(5'b10000));
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    #1;
    chk("after_rst_ready", 32'({o_req0_ready, o_req1_ready}), 32'(2'b10));
    wait_accept(w);
    chk("after_rst_who", 32'(w), 32'd0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    check_frame("drop", 8'h5A, 1'b0, 1'b1);
    quiet = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!(o_tx && !o_busy && !o_req1_ready && !o_req0_ready)) quiet = 1'b0;
      @(negedge i_clk);
    end
    chk("drop_quiet", 32'(quiet), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Shared UART transmit controller for the FPGA board. It arbitrates between two byte requesters, for example a button-event reporter and a periodic status/counter reporter, using round-robin arbitration. It serializes the granted byte onto a single 8N1 TX pin at a fixed baud. It replaces ad-hoc per-bit GPIO toggling with one sequenced, shareable transmitter.

## Interface
Parameters:
- CLKS_PER_BIT, default 2604: i_clk cycles per UART bit (50 MHz / 19200 baud). Legal range 2..4095. The bit counter is 12 bits.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req0_valid  in  1  requester 0 has a byte to send.
- i_req0_data  in  8  requester 0 byte.
- o_req0_ready  out  1  requester 0 byte accepted this cycle when high together with i_req0_valid.
- i_req1_valid  in  1  requester 1 has a byte to send.
- i_req1_data  in  8  requester 1 byte.
- o_req1_ready  out  1  requester 1 acceptance, same rules as requester 0.
- o_tx  out  1  UART serial output; idles high.
- o_busy  out  1  a frame is in progress (START/DATA/STOP).
- o_grant  out  1  index of the requester whose byte is, or was last, being sent.

## Operation
- States: IDLE, START, DATA, STOP. Reset state is IDLE.
- IDLE:
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester not granted last (round-robin pointer `last`). After reset, `last` = 1, so req0 wins the first tie.
- Ready signals are combinational: o_reqN_ready = (state==IDLE) & i_rst_n & (requester N wins). At most one ready is high per cycle. Readies are 0 in every non-IDLE state.
- Acceptance edge (valid & ready):
  - Latch data into an 8-bit shift register.
  - Set o_grant and `last` to the granted index.
  - Clear the bit counter, then go to START.
- START: o_tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: o_tx = shift[0] for CLKS_PER_BIT cycles, shifting right after each bit. Bits go out LSB first. After bit index 7 completes, go to STOP.
- STOP: o_tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- o_busy = 1 in START/DATA/STOP, 0 in IDLE.
- Requester data need only be stable at the acceptance edge. Changes while unaccepted are ignored.
- A valid that is raised and then dropped before IDLE is never accepted and produces no output. There is no request queuing.

## Timing
- Reset values, asynchronous on i_rst_n low: o_tx = 1, o_busy = 0, o_grant = 0, both readies = 0, `last` = 1, shift register = 0, counters = 0.
- Reset during a frame aborts it immediately. o_tx goes high without waiting for a clock, the byte is discarded, and it is not retransmitted.
- o_tx, o_busy and o_grant are registered.
- If acceptance occurs at edge t, o_tx falls and o_busy rises after edge t (the first START cycle is t+1).
- Frame length is exactly 10*CLKS_PER_BIT cycles of o_busy = 1.
- After STOP the block spends at least one cycle in IDLE, where the next acceptance can happen. Back-to-back acceptances are therefore 10*CLKS_PER_BIT + 1 cycles apart.
- Each bit is exactly CLKS_PER_BIT cycles. The counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.

## Test plan
- Reset:
  - Stimulus: hold i_rst_n = 0 with both valids high.
  - Response: o_tx = 1, o_busy = 0, o_grant = 0, both readies 0.
  - Then release reset with only req0 valid. Response: o_req0_ready = 1 in the first post-reset cycle.
- Single byte (CLKS_PER_BIT=4):
  - Stimulus: req0 sends 0x55.
  - Response: o_req0_ready pulses for one cycle. o_tx then shows 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 (4 cycles). o_busy is high for exactly 40 cycles.
- Tie arbitration:
  - Stimulus: both valids held high, req0 = 0xA5, req1 = 0x3C.
  - Response: grants alternate 0,1,0,1. The decoded bytes are A5,3C,A5,3C, and acceptances are 41 cycles apart.
- Single requester:
  - Stimulus: only req1 valid, held high.
  - Response: req1 is accepted every 41 cycles and o_grant = 1 throughout. There are no idle gaps beyond one cycle.
- Reset mid-frame:
  - Stimulus: assert i_rst_n = 0 during DATA bit 3 of 0xFF from req1, then release.
  - Response: o_tx goes high immediately and o_busy = 0.
  - Follow-up: with both valids high after release, req0 is granted first.
- Dropped request:
  - Stimulus: pulse i_req1_valid for 3 cycles while busy with a req0 frame.
  - Response: no req1 ready and no req1 frame. o_tx stays idle high after the req0 frame.
